// File: rtl/cc_bus_pkg.sv
// Shared constants and types for the 6502 bus decode slice.
package cc_bus_pkg;

  // Upper address bits selecting the 9C00-9FFF control page
  localparam logic [5:0] CTRL_PAGE = 6'b100111;

  // Control-page sub-decode on BA[9:7]
  localparam logic [2:0] SUB_NONE   = 3'd0;
  localparam logic [2:0] SUB_HSLD   = 3'd1;
  localparam logic [2:0] SUB_VSLD   = 3'd2;
  localparam logic [2:0] SUB_INTACK = 3'd3;
  localparam logic [2:0] SUB_WDOG   = 3'd4;
  localparam logic [2:0] SUB_OUT0   = 3'd5;
  localparam logic [2:0] SUB_LATCH  = 3'd6;
  localparam logic [2:0] SUB_CRAM   = 3'd7;

  typedef enum logic {
    RUN   = 1'b0,
    PULSE = 1'b1
  } wdog_state_e;

endpackage

// File: rtl/wdog_timer.sv
// Frame watchdog: counts VBLANK rising edges, kicked by WDOG writes, and
// drives a fixed-width active-low CPU reset pulse on timeout.
module wdog_timer
  import cc_bus_pkg::*;
#(
  parameter int unsigned Frames = 8,
  parameter int unsigned Pulse  = 16,
  parameter bit          Enable = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       vblank_i,
  input  logic       kick_i,
  output logic       cpu_reset_no,
  output logic [7:0] wdog_cnt_o
);

  localparam logic [7:0] FramesL = 8'(Frames);
  localparam logic [7:0] PulseM1 = 8'(Pulse - 1);

  wdog_state_e state_q;
  logic        vblank_q;
  logic [7:0]  cnt_q;
  logic [7:0]  pulse_q;
  logic        rst_out_q;
  logic        vblank_rise;

  assign vblank_rise = vblank_i & ~vblank_q;

  // Edge history, frame counter, pulse counter and registered reset output
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= RUN;
      vblank_q  <= 1'b0;
      cnt_q     <= 8'd0;
      pulse_q   <= 8'd0;
      rst_out_q <= 1'b1;
    end else begin
      vblank_q <= vblank_i;
      case (state_q)
        RUN: begin
          if (Enable && (cnt_q == FramesL)) begin
            state_q   <= PULSE;
            pulse_q   <= PulseM1;
            rst_out_q <= 1'b0;
          end else if (kick_i) begin
            // A kick on the same cycle as an edge leaves the count at zero
            cnt_q <= 8'd0;
          end else if (vblank_rise) begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        PULSE: begin
          // Edges and kicks are ignored while the pulse is running
          if (pulse_q == 8'd0) begin
            state_q   <= RUN;
            rst_out_q <= 1'b1;
            cnt_q     <= 8'd0;
          end else begin
            pulse_q <= pulse_q - 8'd1;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign cpu_reset_no = rst_out_q;
  assign wdog_cnt_o   = cnt_q;

endmodule

// File: rtl/io_decode_gen2.sv
// Memory-map decoder for the 6502 bus: chip selects, control-page write
// strobes, OUT0 byte, addressable bit latches and frame watchdog.
module io_decode_gen2
  import cc_bus_pkg::*;
#(
  parameter int unsigned LATCH_BANKS = 1,
  parameter int unsigned LATCH_DBIT  = 3,
  parameter int unsigned WDOG_FRAMES = 8,
  parameter int unsigned WDOG_PULSE  = 16,
  parameter bit          WDOG_EN     = 1'b1
) (
  input  logic                     CLK10,
  input  logic                     RESETn,
  input  logic                     CPU_EN,
  input  logic [15:0]              BA,
  input  logic [7:0]               BD,
  input  logic                     WRITEn,
  input  logic                     VBLANK,
  output logic [2:0]               ROMn,
  output logic                     NRn,
  output logic                     SRAMn,
  output logic                     NVRAMn,
  output logic                     CIOn,
  output logic                     IN0n,
  output logic                     SBUSn,
  output logic                     HSLDn,
  output logic                     VSLDn,
  output logic                     INTACKn,
  output logic                     WDOGn,
  output logic                     CRAMn,
  output logic [7:0]               OUT0_Q,
  output logic [8*LATCH_BANKS-1:0] LATCH_Q,
  output logic                     CPU_RESETn,
  output logic [7:0]               WDOG_CNT
);

  logic       wr_ok;
  logic [2:0] sub;
  logic       latch_wr;
  logic       hsld_q, vsld_q, intack_q, wdog_q, cram_q;
  logic [7:0] out0_q;
  logic       unused_ba;

  // BA[6:5] are don't-care inside the control page
  assign unused_ba = ^BA[6:5];

  // Level chip selects, decoded straight from the address
  always_comb begin
    ROMn[2] = ~(BA[15:13] == 3'b111);
    ROMn[1] = ~(BA[15:13] == 3'b110);
    ROMn[0] = ~(BA[15:13] == 3'b101);
    NRn     = ~(BA[15:13] == 3'b100);
    SRAMn   = ~(BA[15:12] == 4'h8);
    NVRAMn  = ~(BA[15:10] == 6'b100100);
    IN0n    = ~(BA[15:10] == 6'b100101);
    CIOn    = ~(BA[15:10] == 6'b100110);
    SBUSn   = ~((BA[15:12] == 4'h9) && (BA[11:10] != 2'b11));
  end

  assign wr_ok    = CPU_EN & ~WRITEn & (BA[15:10] == CTRL_PAGE);
  assign sub      = BA[9:7];
  assign latch_wr = wr_ok & (sub == SUB_LATCH);

  // One-cycle strobes: CPU_EN qualifies, so a long WRITEn low gives one strobe
  always_ff @(posedge CLK10 or negedge RESETn) begin
    if (!RESETn) begin
      hsld_q   <= 1'b1;
      vsld_q   <= 1'b1;
      intack_q <= 1'b1;
      wdog_q   <= 1'b1;
      cram_q   <= 1'b1;
    end else begin
      hsld_q   <= ~(wr_ok && (sub == SUB_HSLD));
      vsld_q   <= ~(wr_ok && (sub == SUB_VSLD));
      intack_q <= ~(wr_ok && (sub == SUB_INTACK));
      wdog_q   <= ~(wr_ok && (sub == SUB_WDOG));
      cram_q   <= ~(wr_ok && (sub == SUB_CRAM));
    end
  end

  assign HSLDn   = hsld_q;
  assign VSLDn   = vsld_q;
  assign INTACKn = intack_q;
  assign WDOGn   = wdog_q;
  assign CRAMn   = cram_q;

  // OUT0 byte register
  always_ff @(posedge CLK10 or negedge RESETn) begin
    if (!RESETn) begin
      out0_q <= 8'h00;
    end else if (wr_ok && (sub == SUB_OUT0)) begin
      out0_q <= BD;
    end
  end

  assign OUT0_Q = out0_q;

  // Addressable latch banks; banks beyond LATCH_BANKS simply have no storage
  for (genvar b = 0; b < LATCH_BANKS; b++) begin : g_bank
    logic [7:0] bank_q;

    // Single-bit update of the addressed latch, other bits hold
    always_ff @(posedge CLK10 or negedge RESETn) begin
      if (!RESETn) begin
        bank_q <= 8'h00;
      end else if (latch_wr && (BA[4:3] == 2'(b))) begin
        bank_q[BA[2:0]] <= BD[LATCH_DBIT];
      end
    end

    assign LATCH_Q[8*b +: 8] = bank_q;
  end

  wdog_timer #(
    .Frames (WDOG_FRAMES),
    .Pulse  (WDOG_PULSE),
    .Enable (WDOG_EN)
  ) u_wdog_timer (
    .clk_i        (CLK10),
    .rst_ni       (RESETn),
    .vblank_i     (VBLANK),
    .kick_i       (wr_ok && (sub == SUB_WDOG)),
    .cpu_reset_no (CPU_RESETn),
    .wdog_cnt_o   (WDOG_CNT)
  );

endmodule

// File: doc/io_decode_gen2.md
# io_decode_gen2

Parametrised next-generation memory-map decoder for the 6502 bus, running in the `CLK10` domain. It produces:
- level chip-selects for ROM, NR, SRAM, NVRAM, CIO and IN0;
- registered single-cycle write strobes for the 9C00–9FFF control page;
- a configurable bank of addressable bit latches, the generalised 8-bit output latch;
- a full-byte OUT0 register;
- a frame-based watchdog that emits a CPU reset pulse.

It sits between the CPU core and the video, sound and NVRAM blocks.

## Interface
Parameters:
- `LATCH_BANKS`, 1 — number of 8-bit addressable-latch banks at 9F00–9F7F, 1..4; bank index is `BA[4:3]`.
- `LATCH_DBIT`, 3 — data-bus bit written into the addressed latch.
- `WDOG_FRAMES`, 8 — VBLANK edges without a WDOG write before timeout, 1..255.
- `WDOG_PULSE`, 16 — width of `CPU_RESETn` low pulse in `CLK10` cycles, 1..255.
- `WDOG_EN`, 1 — 0 disables the watchdog; `CPU_RESETn` is then held 1.

Ports (`CLK10` and `RESETn` first):
- `CLK10` in 1 — system clock.
- `RESETn` in 1 — reset, asynchronous, active-low.
- `CPU_EN` in 1 — one-cycle bus-cycle-complete qualifier.
- `BA` in 16 — CPU address.
- `BD` in 8 — CPU write data.
- `WRITEn` in 1 — CPU write, active-low.
- `VBLANK` in 1 — video vertical blank level.
- `ROMn` out 3 — {ROM2n, ROM1n, ROM0n}, combinational, active-low.
- `NRn`, `SRAMn`, `NVRAMn`, `CIOn`, `IN0n`, `SBUSn` out 1 each — combinational selects, decoded as the existing map.
- `HSLDn`, `VSLDn`, `INTACKn`, `WDOGn`, `CRAMn` out 1 each — registered write strobes, active-low.
- `OUT0_Q` out 8 — OUT0 byte register.
- `LATCH_Q` out `8*LATCH_BANKS` — addressable latch bits; bank b occupies bits [8b+7:8b].
- `CPU_RESETn` out 1 — watchdog reset to CPU, active-low.
- `WDOG_CNT` out 8 — current frame count, for debug.

## Operation
- Combinational selects use the fixed map:
  - E000/C000/A000 → `ROMn[2:0]`; 8000–9FFF → `NRn`.
  - 8000–8FFF → `SRAMn`.
  - 9000/9400/9800 → `NVRAMn`/`IN0n`/`CIOn`.
  - `SBUSn` is low for 9000–9BFF.
- Control-page write, `wr_ok` = `CPU_EN & ~WRITEn & BA[15:10]==6'b100111`. Sub-decode on `BA[9:7]`:
  - 1 → HSLD, 2 → VSLD, 3 → INTACK, 4 → WDOG, 5 → OUT0, 6 → latch, 7 → CRAM, 0 → ignored.
- Strobes: the registered output is low for exactly one `CLK10` cycle after the `wr_ok` edge, regardless of how long `WRITEn` stays low.
- OUT0: `OUT0_Q <= BD` on OUT0 write.
- Latch write: bank `BA[4:3]`, bit `BA[2:0]`, value `BD[LATCH_DBIT]`.
  - Writes to bank ≥ `LATCH_BANKS` are ignored.
  - All other bits hold their value.
- Watchdog counter:
  - Increments on each VBLANK rising edge, detected with a one-flop history.
  - Cleared by a WDOG write; a WDOG write coincident with a VBLANK edge leaves the counter at 0 (kick wins).
  - When the count reaches `WDOG_FRAMES`: enter PULSE, drive `CPU_RESETn` = 0 for `WDOG_PULSE` cycles, then return to RUN with the counter cleared.
  - In PULSE, VBLANK edges and WDOG writes are ignored.
- Watchdog states: RUN → PULSE (on timeout) → RUN (pulse counter expires).
- Reset values:
  - Strobes 1; `OUT0_Q` 0; `LATCH_Q` 0; `CPU_RESETn` 1.
  - `WDOG_CNT` 0; state RUN; VBLANK history 0.

## Timing
- Selects: combinational, zero latency.
- Strobes, `OUT0_Q`, `LATCH_Q`: update on the `CLK10` edge where `wr_ok` is sampled high, visible the next cycle; strobe width is 1 cycle.
- Back-to-back `CPU_EN` writes give consecutive strobes; no minimum gap.
- VBLANK edge to `WDOG_CNT` increment: 1 cycle after the sampled edge.
- Timeout: `CPU_RESETn` falls on the cycle after the count reaches `WDOG_FRAMES` and rises after exactly `WDOG_PULSE` low cycles.
- `RESETn` asserted mid-pulse forces `CPU_RESETn` = 1 immediately (asynchronous) and the state to RUN.

## Structure
- Shared package `cc_bus_pkg` holds:
  - the page constants (`CTRL_PAGE`=6'b100111, sub-decode codes 0–7);
  - the watchdog state enum {RUN, PULSE}.
- Natural sub-module: `wdog_timer` (edge detect, frame counter, pulse counter, state machine).
- The addressable latch bank stays inline as a generate loop over `LATCH_BANKS`.

## Test plan
- Reset, then write 9C80 with `CPU_EN` pulsed, `WRITEn` held low for 4 cycles → `HSLDn` low for exactly 1 cycle; other strobes stay 1.
- `LATCH_BANKS`=2: write 9F0B with `BD`=0x08 → `LATCH_Q[11]`=1, all other bits 0. Write 9F1B with `BD`=0x08 → ignored.
- Write 9E80 with `BD`=0xA5 → `OUT0_Q`=0xA5 next cycle. Write 9C00 → no strobe, no state change.
- `WDOG_FRAMES`=3, `WDOG_PULSE`=5, no kicks, 3 VBLANK edges → `CPU_RESETn` low 5 cycles, then `WDOG_CNT`=0 and state RUN.
- WDOG write in the same cycle as the 3rd VBLANK edge → `WDOG_CNT`=0 and no reset pulse.
- `RESETn` low during a watchdog pulse → `CPU_RESETn`=1 immediately, `LATCH_Q`=0, `OUT0_Q`=0.
